uart_hex_tx: RTL and testbench

//   Formats a WIDTH-bit word as ASCII hex text and streams it into the uart transmitter's byte interface.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/hex_digit.sv | 17 +
 rtl/uart_hex_tx.sv | 115 +++++++++++
 tb/tb_uart_hex_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the uart byte-stream helpers: ASCII codes and the hex printer state encoding.
package uart_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_X  = 8'h78;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int unsigned HexTxStateW = 3;

  typedef enum logic [HexTxStateW-1:0] {
    StIdle = 3'd0,
    StP0   = 3'd1,
    StP1   = 3'd2,
    StDig  = 3'd3,
    StCr   = 3'd4,
    StLf   = 3'd5
  } hex_tx_state_e;

endpackage

// File: rtl/hex_digit.sv
// Combinational nibble to uppercase ASCII hex character.
module hex_digit
  import uart_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii_o = ASCII_0 + {4'h0, nibble_i};
    end else begin
      ascii_o = ASCII_A + {4'h0, nibble_i} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_hex_tx.sv
// Prints a WIDTH-bit word as ASCII hex (optional "0x" prefix and CR/LF) into the uart byte port,
// one byte per txd_ready window with never two strobes in a row.
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PREFIX  = 1,
  parameter int unsigned NEWLINE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             value_strobe,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       txd,
  output logic             txd_strobe,
  input  logic             txd_ready
);

  localparam int unsigned NumDigits = WIDTH / 4;
  localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [CntW-1:0] LastDigit = CntW'(NumDigits - 1);

  localparam hex_tx_state_e FirstSt  = (PREFIX != 0) ? StP0 : StDig;
  localparam hex_tx_state_e AfterDig = (NEWLINE != 0) ? StCr : StIdle;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : gen_bad_width
    $error("uart_hex_tx: WIDTH must be a multiple of 4 and at least 4");
  end

  hex_tx_state_e    state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       txd_q, txd_d;
  logic             txd_strobe_q, txd_strobe_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       digit_ascii;
  logic             accept, send, last_digit;

  hex_digit u_hex_digit (
    .nibble_i (shift_q[WIDTH-1 -: 4]),
    .ascii_o  (digit_ascii)
  );

  // busy covers the final strobe cycle so a new request never overlaps the last byte.
  assign busy       = (state_q != StIdle) || txd_strobe_q;
  assign accept     = value_strobe && !busy;
  assign send       = (state_q != StIdle) && txd_ready && !txd_strobe_q;
  assign last_digit = (cnt_q == LastDigit);

  assign txd        = txd_q;
  assign txd_strobe = txd_strobe_q;
  assign overrun    = overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      cnt_q        <= '0;
      txd_q        <= 8'h00;
      txd_strobe_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      txd_q        <= txd_d;
      txd_strobe_q <= txd_strobe_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = FirstSt;
      StP0:    if (send) state_d = StP1;
      StP1:    if (send) state_d = StDig;
      StDig:   if (send && last_digit) state_d = AfterDig;
      StCr:    if (send) state_d = StLf;
      StLf:    if (send) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    txd_d        = txd_q;
    txd_strobe_d = send;
    overrun_d    = value_strobe && busy;
    if (send) begin
      unique case (state_q)
        StP0:    txd_d = ASCII_0;
        StP1:    txd_d = ASCII_X;
        StDig:   txd_d = digit_ascii;
        StCr:    txd_d = ASCII_CR;
        StLf:    txd_d = ASCII_LF;
        default: txd_d = txd_q;
      endcase
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (accept) begin
      shift_d = value;
      cnt_d   = '0;
    end else if (send && (state_q == StDig)) begin
      shift_d = shift_q << 4;
      cnt_d   = cnt_q + CntW'(1);
    end
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx: default 32-bit printer against a simple uart ready model,
// plus an 8-bit digits-only instance.
module tb_uart_hex_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic        value_strobe;
  logic        busy, overrun, txd_strobe, txd_ready;
  logic [7:0]  txd;

  logic [7:0]  s_value;
  logic        s_value_strobe;
  logic        s_busy, s_overrun, s_txd_strobe;
  logic [7:0]  s_txd;
  logic        s_txd_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int gap = 0;
  int stall_at = 0;
  int stall_len = 0;
  int ov_total = 0;
  byte unsigned rx[$];
  int           stb_t[$];
  byte unsigned rx2[$];

  always #5 clk = ~clk;

  uart_hex_tx #(.WIDTH(32), .PREFIX(1), .NEWLINE(1)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .value        (value),
    .value_strobe (value_strobe),
    .busy         (busy),
    .overrun      (overrun),
    .txd          (txd),
    .txd_strobe   (txd_strobe),
    .txd_ready    (txd_ready)
  );

  uart_hex_tx #(.WIDTH(8), .PREFIX(0), .NEWLINE(0)) u_small (
    .clk          (clk),
    .reset        (reset),
    .value        (s_value),
    .value_strobe (s_value_strobe),
    .busy         (s_busy),
    .overrun      (s_overrun),
    .txd          (s_txd),
    .txd_strobe   (s_txd_strobe),
    .txd_ready    (s_txd_ready)
  );

  // uart model: ready drops after each strobe and returns after gap (or stall_len) cycles
  assign txd_ready = (rdy_cnt == 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (txd_strobe) begin
      rx.push_back(txd);
      stb_t.push_back(cyc);
      if (rx.size() == stall_at) rdy_cnt <= stall_len;
      else rdy_cnt <= gap;
    end else if (rdy_cnt > 0) begin
      rdy_cnt <= rdy_cnt - 1;
    end
    if (s_txd_strobe) rx2.push_back(s_txd);
  end

  always @(negedge clk) begin
    if (overrun) ov_total <= ov_total + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_value(input logic [31:0] v);
    value        = v;
    value_strobe = 1'b1;
    @(negedge clk);
    value_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (!busy) else begin
      errors++;
      $error("FAIL %s: busy got %0b after %0d cycles expected 0", tag, busy, budget);
    end
  endtask

  task automatic check_msg(input string tag, input int base, input string exp);
    int got = rx.size() - base;
    chk({tag, " len"}, got, exp.len());
    for (int i = 0; i < exp.len() && i < got; i++) begin
      chk($sformatf("%s byte%0d", tag, i), rx[base + i], exp[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, k, t_idle, ov0, n;

    reset          = 1'b1;
    value          = '0;
    value_strobe   = 1'b0;
    s_value        = '0;
    s_value_strobe = 1'b0;
    tick(3);
    chk("rst busy", busy, 1'b0);
    chk("rst overrun", overrun, 1'b0);
    chk("rst txd_strobe", txd_strobe, 1'b0);
    chk("rst txd", txd, 8'h00);
    chk("rst small busy", s_busy, 1'b0);
    reset = 1'b0;
    tick(2);

    // Ready always high; value changes after acceptance must not matter
    gap  = 0;
    base = rx.size();
    k    = cyc;
    send_value(32'h0000_BEEF);
    value = 32'hDEAD_0000;
    chk("beef busy N+1", busy, 1'b1);
    chk("beef no strobe N+1", txd_strobe, 1'b0);
    @(negedge clk);
    chk("beef strobe N+2", txd_strobe, 1'b1);
    chk("beef first txd", txd, 8'h30);
    wait_idle("beef idle", 100);
    t_idle = cyc;
    check_msg("beef", base, "0x0000BEEF\r\n");
    if (stb_t.size() >= base + 12) begin
      chk("beef t0", stb_t[base], k + 2);
      for (int i = 1; i < 12; i++) begin
        chk($sformatf("beef spacing%0d", i), stb_t[base + i] - stb_t[base + i - 1], 2);
      end
      chk("beef busy fall", t_idle, stb_t[base + 11] + 1);
    end
    tick(5);
    chk("beef no extra", rx.size() - base, 12);

    // Ready held low for 100 cycles after the 3rd byte
    base      = rx.size();
    stall_at  = base + 3;
    stall_len = 100;
    send_value(32'h1234_5678);
    wait_idle("stall idle", 400);
    check_msg("stall", base, "0x12345678\r\n");
    if (stb_t.size() >= base + 4) begin
      chk("stall gap", (stb_t[base + 3] - stb_t[base + 2]) >= 100, 1'b1);
    end
    stall_at = 0;

    // Second request two cycles after the first is dropped
    gap  = 2;
    base = rx.size();
    ov0  = ov_total;
    send_value(32'hAAAA_AAAA);
    tick(1);
    chk("ovr busy", busy, 1'b1);
    value        = 32'h5555_5555;
    value_strobe = 1'b1;
    @(negedge clk);
    value_strobe = 1'b0;
    chk("ovr pulse", overrun, 1'b1);
    @(negedge clk);
    chk("ovr pulse end", overrun, 1'b0);
    wait_idle("ovr idle", 200);
    check_msg("ovr", base, "0xAAAAAAAA\r\n");
    chk("ovr count", ov_total - ov0, 1);

    // Back-to-back in the first cycle busy reads 0
    base = rx.size();
    send_value(32'h0000_0000);
    chk("b2b accepted", busy, 1'b1);
    chk("b2b no overrun", overrun, 1'b0);
    wait_idle("b2b idle", 200);
    check_msg("b2b", base, "0x00000000\r\n");
    gap = 0;

    // Reset after 5 bytes abandons the rest
    base = rx.size();
    send_value(32'hFFFF_FFFF);
    n = 0;
    while ((rx.size() - base) < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid reached 5", rx.size() - base, 5);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid busy", busy, 1'b0);
    chk("rstmid strobe", txd_strobe, 1'b0);
    reset = 1'b0;
    tick(20);
    chk("rstmid no more", rx.size() - base, 5);
    base = rx.size();
    send_value(32'h0000_0001);
    wait_idle("after rst idle", 100);
    check_msg("after rst", base, "0x00000001\r\n");

    // WIDTH=8, no prefix, no newline
    s_value        = 8'h9C;
    s_value_strobe = 1'b1;
    @(negedge clk);
    s_value_strobe = 1'b0;
    tick(10);
    chk("small len", rx2.size(), 2);
    if (rx2.size() >= 2) begin
      chk("small byte0", rx2[0], 8'h39);
      chk("small byte1", rx2[1], 8'h43);
    end
    chk("small idle", s_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
